// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 3;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between IF and DM plus the saturating IF-starvation counter.
// DM wins by default; IF wins when DM is idle or IF has been passed over
// STARVE_MAX times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant,
  output owner_t winner
);

  localparam int SW = cnt_w(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign winner = (if_req && (!dm_req || starve_cnt == SW'(STARVE_MAX))) ? OWN_IF : OWN_DM;

  // Count DM grants that bypass a waiting IF; any other grant restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (grant) begin
      if (winner == OWN_IF || !if_req)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit single-port memory between instruction fetch (IF) and
// data memory (DM). One access at a time: grant in IDLE, hold the memory for
// MEM_LAT cycles in ACCESS, pulse done in RESP.
// Optional macro ARB_ALIGN_CHK_EN: odd addresses are rejected with an err pulse
// instead of touching memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [15:0]           if_rdata,
  output logic                  if_done,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [15:0]           dm_wdata,
  output logic [15:0]           dm_rdata,
  output logic                  dm_done,
  output logic                  dm_stall,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  output logic                  err
);

  localparam int LW = cnt_w(MEM_LAT);

  arb_state_t            state, state_nx;
  owner_t                own, winner;
  logic [ADDR_WIDTH-1:0] a_addr, win_addr;
  logic                  a_wr;
  logic [15:0]           a_wdata;
  logic [LW-1:0]         lat_cnt;
  logic                  grant, last, mis;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .grant  (grant),
    .winner (winner)
  );

  assign win_addr = (winner == OWN_IF) ? if_addr : dm_addr;
  assign last     = (state == ACCESS) && (lat_cnt == '0);

`ifdef ARB_ALIGN_CHK_EN
  logic a_err;
  assign mis = win_addr[0];
  assign err = (state == RESP) && a_err;

  // Remember whether the granted access was rejected for misalignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       a_err <= 1'b0;
    else if (grant) a_err <= mis;
  end
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif

  // Next state and grant decision; requests are only sampled in IDLE.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE:    if (if_req || dm_req) begin
                 grant    = 1'b1;
                 state_nx = mis ? RESP : ACCESS;
               end
      ACCESS:  if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side and requester-side outputs decoded from the registered state.
  always_comb begin
    mem_enable  = (state == ACCESS);
    mem_wr      = last && a_wr;
    mem_addr    = mem_enable ? (a_addr & ~ADDR_WIDTH'(1)) : '0;
    mem_data_in = mem_enable ? a_wdata : '0;
    if_done     = (state == RESP) && (own == OWN_IF);
    dm_done     = (state == RESP) && (own == OWN_DM);
    if_stall    = if_req && !if_done;
    dm_stall    = dm_req && !dm_done;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Latch the granted request and run the hold-time counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own     <= OWN_IF;
      a_addr  <= '0;
      a_wr    <= 1'b0;
      a_wdata <= '0;
      lat_cnt <= '0;
    end else if (grant) begin
      own     <= winner;
      a_addr  <= win_addr;
      a_wr    <= (winner == OWN_DM) && dm_wr;
      a_wdata <= (winner == OWN_DM) ? dm_wdata : '0;
      lat_cnt <= LW'(MEM_LAT - 1);
    end else if (state == ACCESS && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Per-port read data: captured on the final ACCESS cycle of a read only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (last && !a_wr) begin
      if (own == OWN_IF) if_rdata <= mem_data_out;
      else               dm_rdata <= mem_data_out;
    end
`ifdef ARB_ALIGN_CHK_EN
    else if (grant && mis) begin
      if (winner == OWN_IF) if_rdata <= '0;
      else                  dm_rdata <= '0;
    end
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural 256-word memory.
module tb_mem_port_arbiter;

  localparam int AW         = 16;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic          clk, rst;
  logic          if_req, dm_req, dm_wr;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [15:0]   dm_wdata, if_rdata, dm_rdata, mem_data_in, mem_data_out;
  logic          if_done, if_stall, dm_done, dm_stall, mem_enable, mem_wr, err;

  logic [15:0]   tbmem [256];
  logic          mem_clr;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_if, exp_dm;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_out = tbmem[mem_addr[8:1]];

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) tbmem[i] <= 16'h0;
    else if (mem_enable && mem_wr) tbmem[mem_addr[8:1]] <= mem_data_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-port access: drive, wait for done, check latency and side effects.
  task automatic run_acc(input string nm, input bit dm, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] rd,
                         input int exp_lat, input int exp_en, input bit exp_err);
    int n, en, wrc;
    bit got, e;
    n = 0; en = 0; wrc = 0; got = 0; e = 0;
    if (dm) begin
      dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    chk({nm, "_stall"}, dm ? dm_stall : if_stall, 1);
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      en  += int'(mem_enable);
      wrc += int'(mem_wr);
      if (dm ? dm_done : if_done) begin
        got = 1; n = i; e = err;
      end
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_en_cycles"}, en, exp_en);
    chk({nm, "_wr_cycles"}, wrc, (wr && !exp_err) ? 1 : 0);
    chk({nm, "_err"}, e, exp_err);
    if (exp_err)  begin if (dm) exp_dm = 16'h0; else exp_if = 16'h0; end
    else if (!wr) begin if (dm) exp_dm = rd;    else exp_if = rd;    end
    chk({nm, "_dm_rdata"}, dm_rdata, exp_dm);
    chk({nm, "_if_rdata"}, if_rdata, exp_if);
    if (dm) dm_req = 1'b0; else if_req = 1'b0;
    tick();
    chk({nm, "_done_pulse"}, dm ? dm_done : if_done, 0);
  endtask

  typedef struct {
    bit          dm;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [8];
  bit   order_exp [5];
  bit   order_got [5];

  initial begin
    int k, last_cyc, n;
    bit got, stall_bad;

    vecs[0] = '{1, 1, 16'h0002, 16'h1234, 16'h0000};
    vecs[1] = '{1, 1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[2] = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[3] = '{0, 0, 16'h0002, 16'h0000, 16'h1234};
    vecs[4] = '{1, 1, 16'h0006, 16'h0F0F, 16'h0000};
    vecs[5] = '{1, 0, 16'h0006, 16'h0000, 16'h0F0F};
    vecs[6] = '{0, 0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[7] = '{1, 0, 16'h0002, 16'h0000, 16'h1234};
    order_exp = '{1, 1, 1, 0, 1};

    rst = 1'b0; mem_clr = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
    exp_if = 16'h0; exp_dm = 16'h0;
    #12;
    chk("rst_outs", {if_rdata, dm_rdata}, 32'h0);
    chk("rst_ctl", {if_done, if_stall, dm_done, dm_stall, mem_enable, mem_wr, err}, 0);
    chk("rst_mem", {mem_addr, mem_data_in}, 32'h0);
    tick();
    mem_clr = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_en", mem_enable, 0);

    // Single-port accesses from the vector table.
    for (int v = 0; v < 8; v++) begin
      run_acc($sformatf("vec%0d", v), vecs[v].dm, vecs[v].wr, vecs[v].addr,
              vecs[v].wdata, vecs[v].rd, MEM_LAT + 1, MEM_LAT, 0);
      if (vecs[v].wr)
        chk($sformatf("vec%0d_memword", v), tbmem[vecs[v].addr[8:1]], vecs[v].wdata);
    end

    // Both ports requesting continuously: DM x3, IF, DM.
    if_req = 1; if_addr = 16'h0002;
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0010;
    k = 0; last_cyc = 0; stall_bad = 0;
    for (int c = 1; c <= 40 && k < 5; c++) begin
      tick();
      if (if_done && dm_done) stall_bad = 1;
      if (k < 3 && !if_done && !if_stall) stall_bad = 1;
      if (if_done || dm_done) begin
        order_got[k] = dm_done;
        chk($sformatf("arb_order%0d", k), order_got[k], order_exp[k]);
        if (k > 0) chk($sformatf("arb_gap%0d", k), c - last_cyc, MEM_LAT + 2);
        if (k == 3) chk("arb_if_stall_at_done", if_stall, 0);
        last_cyc = c;
        k++;
      end
    end
    chk("arb_dones", k, 5);
    chk("arb_stall_ok", stall_bad, 0);
    exp_dm = 16'hBEEF; exp_if = 16'h1234;
    chk("arb_rdata", {if_rdata, dm_rdata}, {exp_if, exp_dm});
    if_req = 0; dm_req = 0;
    tick(); tick();

    // Reset during the first ACCESS cycle of a write.
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0020; dm_wdata = 16'hAAAA;
    tick();
    chk("rst_mid_en_before", mem_enable, 1);
    #2 rst = 1'b0;
    dm_req = 0; dm_wr = 0;
    #1;
    chk("rst_mid_ctl", {dm_done, mem_enable, mem_wr, err}, 0);
    chk("rst_mid_rdata", {if_rdata, dm_rdata}, 32'h0);
    tick();
    rst = 1'b1;
    exp_if = 16'h0; exp_dm = 16'h0;
    tick();
    chk("rst_mid_idle", {mem_enable, dm_done}, 0);
    chk("rst_mid_memword", tbmem[8'h10], 16'h0000);

    // Request dropped right after the grant: write still completes.
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0004; dm_wdata = 16'h5A5A;
    tick();
    dm_req = 0;
    got = 0; n = 1;
    for (int i = 2; i <= 10 && !got; i++) begin
      tick();
      if (dm_done) begin got = 1; n = i; end
    end
    chk("drop_done", got, 1);
    chk("drop_lat", n, MEM_LAT + 1);
    tick();
    chk("drop_memword", tbmem[2], 16'h5A5A);
    run_acc("drop_rb", 1, 0, 16'h0004, 16'h0, 16'h5A5A, MEM_LAT + 1, MEM_LAT, 0);

    // Odd DM read address.
`ifdef ARB_ALIGN_CHK_EN
    run_acc("odd", 1, 0, 16'h0003, 16'h0, 16'h0000, 1, 0, 1);
`else
    run_acc("odd", 1, 0, 16'h0003, 16'h0, 16'h1234, MEM_LAT + 1, MEM_LAT, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
